// File: rtl/fifo_ptr_pkg.sv
// rtl/fifo_ptr_pkg.sv - Gray/binary pointer helpers shared by the FIFO pointer controllers
package fifo_ptr_pkg;

  localparam int PTR_MAX_W = 32;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of every Gray bit at or above it; zero-extension keeps this width-agnostic.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin = '0;
    for (int i = 0; i < PTR_MAX_W; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// rtl/gray2bin_conv.sv - combinational WIDTH-bit Gray-to-binary converter
module gray2bin_conv
  import fifo_ptr_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin = WIDTH'(gray2bin(PTR_MAX_W'(gray)));

endmodule

// File: rtl/write_pointer_ctrl.sv
// rtl/write_pointer_ctrl.sv - async FIFO write-side pointer, full/almost-full, free count, overflow
module write_pointer_ctrl
  import fifo_ptr_pkg::*;
#(
  parameter int ADDBITS      = 2,
  parameter int AFULL_THRESH = 1,
  localparam int WIDTH       = ADDBITS + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               count,
  input  logic [WIDTH-1:0]   rpointer,
  input  logic               ovf_clr,
  output logic [WIDTH-1:0]   wpointer,
  output logic [ADDBITS-1:0] waddr,
  output logic               wen,
  output logic               full,
  output logic               almost_full,
  output logic [WIDTH-1:0]   wfree,
  output logic               overflow
);

  localparam int               DEPTH    = 1 << ADDBITS;
  localparam logic [WIDTH-1:0] DEPTH_W  = WIDTH'(DEPTH);
  localparam logic [WIDTH-1:0] THRESH_W = WIDTH'(AFULL_THRESH);

  logic [WIDTH-1:0] wbin;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic [WIDTH-1:0] rbin;
  logic [WIDTH-1:0] full_ptr;
  logic [WIDTH-1:0] used;
  logic [WIDTH-1:0] free_next;

  gray2bin_conv #(.WIDTH(WIDTH)) u_rptr_conv (
    .gray (rpointer),
    .bin  (rbin)
  );

  assign wen       = count & ~full & ~rst;
  assign waddr     = wbin[ADDBITS-1:0];
  assign bin_next  = wbin + WIDTH'(wen);
  assign gray_next = WIDTH'(bin2gray(PTR_MAX_W'(bin_next)));

  // One full lap ahead of the reader: the two top Gray bits differ, the rest match.
  assign full_ptr  = {~rpointer[WIDTH-1:WIDTH-2], rpointer[WIDTH-3:0]};
  assign used      = bin_next - rbin;
  assign free_next = DEPTH_W - used;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin        <= '0;
      wpointer    <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wfree       <= DEPTH_W;
      overflow    <= 1'b0;
    end else begin
      wbin        <= bin_next;
      wpointer    <= gray_next;
      full        <= (gray_next == full_ptr);
      almost_full <= (free_next <= THRESH_W);
      wfree       <= free_next;
      // A rejected write in the same cycle as a clear keeps the flag set.
      if (count & full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_write_pointer_ctrl.sv
// tb/tb_write_pointer_ctrl.sv - scoreboard bench for write_pointer_ctrl with a counting reference model
module tb_write_pointer_ctrl;

  localparam int AB    = 2;
  localparam int W     = AB + 1;
  localparam int DEPTH = 1 << AB;
  localparam int TH    = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         count = 1'b0;
  logic [W-1:0] rpointer = '0;
  logic         ovf_clr = 1'b0;
  logic [W-1:0] wpointer;
  logic [AB-1:0] waddr;
  logic         wen;
  logic         full;
  logic         almost_full;
  logic [W-1:0] wfree;
  logic         overflow;

  write_pointer_ctrl #(.ADDBITS(AB), .AFULL_THRESH(TH)) dut (
    .clk         (clk),
    .rst         (rst),
    .count       (count),
    .rpointer    (rpointer),
    .ovf_clr     (ovf_clr),
    .wpointer    (wpointer),
    .waddr       (waddr),
    .wen         (wen),
    .full        (full),
    .almost_full (almost_full),
    .wfree       (wfree),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wen;
    logic [AB-1:0] waddr;
    logic [W-1:0]  wptr;
    logic          full;
    logic          af;
    logic [W-1:0]  wfree;
    logic          ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: absolute write/read counts since reset, plus expected registered outputs.
  int           m_wr;
  int           m_rd;
  logic         m_full;
  logic         m_af;
  logic         m_ovf;
  logic [W-1:0] m_wptr;
  logic [W-1:0] m_wfree;

  function automatic logic [W-1:0] to_gray(input int n);
    int m;
    m = n % (1 << W);
    return W'(m ^ (m >> 1));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0;
    m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
    m_wptr = '0; m_wfree = W'(DEPTH);
  endtask

  // One clock cycle: drive inputs at the falling edge, queue expectations, advance the model over the rising edge.
  task automatic step(input logic c, input logic clr, input int new_rd);
    exp_t e;
    logic accept;
    int   used;
    @(negedge clk);
    rst = 1'b0; count = c; ovf_clr = clr;
    m_rd = new_rd;
    rpointer = to_gray(m_rd);
    accept = c && !m_full;
    e.wen = accept; e.waddr = AB'(m_wr % DEPTH);
    e.wptr = m_wptr; e.full = m_full; e.af = m_af; e.wfree = m_wfree; e.ovf = m_ovf;
    exp_q.push_back(e);
    if (c && m_full) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (accept) m_wr++;
    used    = m_wr - m_rd;
    m_full  = (used == DEPTH);
    m_wfree = W'(DEPTH - used);
    m_af    = ((DEPTH - used) <= TH);
    m_wptr  = to_gray(m_wr);
  endtask

  // Reset asserted between clock edges, so outputs must clear before any rising edge.
  task automatic do_reset(input logic c);
    exp_t e;
    @(negedge clk);
    count = c; ovf_clr = 1'b0;
    #1 rst = 1'b1;
    rpointer = '0;
    model_reset();
    e.wen = 1'b0; e.waddr = '0; e.wptr = '0; e.full = 1'b0; e.af = 1'b0;
    e.wfree = W'(DEPTH); e.ovf = 1'b0;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wen",         32'(wen),         32'(e.wen));
        chk("waddr",       32'(waddr),       32'(e.waddr));
        chk("wpointer",    32'(wpointer),    32'(e.wptr));
        chk("full",        32'(full),        32'(e.full));
        chk("almost_full", 32'(almost_full), 32'(e.af));
        chk("wfree",       32'(wfree),       32'(e.wfree));
        chk("overflow",    32'(overflow),    32'(e.ovf));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int waited;
    model_reset();
    repeat (2) @(negedge clk);

    do_reset(1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 0);
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1);
    step(1'b1, 1'b0, 1);
    step(1'b0, 1'b0, 1);
    step(1'b0, 1'b0, 2);
    step(1'b0, 1'b0, 3);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, m_wr - 1);
    step(1'b0, 1'b0, m_rd);

    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0);
    do_reset(1'b1);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);

    for (int i = 0; i < 400; i++) begin
      int nrd;
      nrd = m_rd;
      if (m_rd < m_wr && ($urandom_range(0, 2) != 0)) nrd = m_rd + 1;
      if ($urandom_range(0, 99) == 0) do_reset($urandom_range(0, 1) == 1);
      else step(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), nrd);
    end
    step(1'b0, 1'b0, m_rd);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    #10;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
